risc_v_multicycle: RTL and testbench

Multi-cycle successor to the single-cycle `risc_v` core. One shared ALU, an internal 32x32 register file and a state machine execute the RV32I subset over a single unified memory port with a request/ready handshake, so instruction and data memory can be shared and can stall the core. It sits at the top of the CPU hierarchy in place of `risc_v`, with memory external.

---
 rtl/risc_v_multicycle.sv | 207 ++++++++++++++++++++
 tb/tb_risc_v_multicycle.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_multicycle.sv
// risc_v_multicycle: multi-cycle RV32I-subset core (lw, sw, add, sub, and, or,
// slt, addi, andi, ori, slti, beq, bne, jal). It has one shared ALU, an internal
// 32x32 register file and a single unified memory port that uses a req/ready
// handshake.
// Optional feature: define RISC_V_MC_ILLEGAL_TRAP_EN to halt on unsupported
// encodings. When it is undefined, they retire as NOPs.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4
// DECODE | read rs1/rs2, precompute branch/jump target, dispatch
// MEMADR | effective address for lw/sw
// MEMRD  | load access
// MEMWB  | write loaded word to rd
// MEMWR  | store access
// EXECR  | register-register ALU op
// EXECI  | register-immediate ALU op
// ALUWB  | write ALUOut to rd
// BRANCH | compare and redirect PC if taken
// JAL    | redirect PC, link value into ALUOut
// HALT   | illegal instruction trap (only with the trap macro)
module risc_v_multicycle #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [31:0]           instret,
  output logic                  illegal
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6,
    S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10;
`ifdef RISC_V_MC_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_HALT = 4'd11;
`endif
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
    ALU_OR = 3'd3, ALU_SLT = 3'd4;

  logic [3:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc, r_oldpc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [DATA_WIDTH-1:0] r_rf [0:31];
  logic [31:0]           r_instret;

  logic [6:0]            w_opcode, w_f7;
  logic [4:0]            w_rd, w_rs1, w_rs2;
  logic [2:0]            w_f3, w_fn_op, w_alu_op;
  logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic [DATA_WIDTH-1:0] w_alu_a, w_alu_b, w_alu_y;
  logic                  w_alu_zero, w_f3_alu_ok, w_is_mem, w_is_r, w_is_i;
  logic                  w_is_br, w_is_jal, w_br_taken;
  logic [ADDR_WIDTH-3:0] w_word_addr;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];
  assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign w_f3_alu_ok = (w_f3 == 3'b000) || (w_f3 == 3'b111) || (w_f3 == 3'b110) || (w_f3 == 3'b010);
  assign w_is_mem = ((w_opcode == OP_LOAD) || (w_opcode == OP_STORE)) && (w_f3 == 3'b010);
  assign w_is_r   = (w_opcode == OP_R) && w_f3_alu_ok &&
                    ((w_f7 == 7'b0000000) || ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
  assign w_is_i   = (w_opcode == OP_I) && w_f3_alu_ok;
  assign w_is_br  = (w_opcode == OP_BR) && ((w_f3 == 3'b000) || (w_f3 == 3'b001));
  assign w_is_jal = (w_opcode == OP_JAL);

  // funct3 to ALU operation; sub only exists in the register-register form
  always_comb begin
    case (w_f3)
      3'b111:  w_fn_op = ALU_AND;
      3'b110:  w_fn_op = ALU_OR;
      3'b010:  w_fn_op = ALU_SLT;
      default: w_fn_op = (w_opcode == OP_R && w_f7[5]) ? ALU_SUB : ALU_ADD;
    endcase
  end

  // Shared ALU operand select; the default (FETCH) computes PC+4
  always_comb begin
    w_alu_a  = r_pc;
    w_alu_b  = 32'd4;
    w_alu_op = ALU_ADD;
    case (r_state)
      S_DECODE: begin w_alu_a = r_oldpc; w_alu_b = w_is_jal ? w_imm_j : w_imm_b; end
      S_MEMADR: begin w_alu_a = r_a; w_alu_b = (w_opcode == OP_STORE) ? w_imm_s : w_imm_i; end
      S_EXECR:  begin w_alu_a = r_a; w_alu_b = r_b;     w_alu_op = w_fn_op; end
      S_EXECI:  begin w_alu_a = r_a; w_alu_b = w_imm_i; w_alu_op = w_fn_op; end
      S_BRANCH: begin w_alu_a = r_a; w_alu_b = r_b;     w_alu_op = ALU_SUB; end
      S_JAL:    begin w_alu_a = r_oldpc; end
      default:  ;
    endcase
  end

  // ALU function
  always_comb begin
    case (w_alu_op)
      ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
      ALU_AND: w_alu_y = w_alu_a & w_alu_b;
      ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
      ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      default: w_alu_y = w_alu_a + w_alu_b;
    endcase
  end

  assign w_alu_zero = (w_alu_y == '0);
  assign w_br_taken = (w_f3 == 3'b000) ? w_alu_zero : !w_alu_zero;

  // Main FSM and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_oldpc   <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir <= mem_rdata; r_oldpc <= r_pc; r_pc <= w_alu_y; r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a      <= r_rf[w_rs1];
          r_b      <= r_rf[w_rs2];
          r_aluout <= w_alu_y;
          if (w_is_mem)      r_state <= S_MEMADR;
          else if (w_is_r)   r_state <= S_EXECR;
          else if (w_is_i)   r_state <= S_EXECI;
          else if (w_is_br)  r_state <= S_BRANCH;
          else if (w_is_jal) r_state <= S_JAL;
          else begin
`ifdef RISC_V_MC_ILLEGAL_TRAP_EN
            r_state <= S_HALT;
`else
            r_state <= S_FETCH; r_instret <= r_instret + 32'd1;
`endif
          end
        end
        S_MEMADR: begin
          r_aluout <= w_alu_y;
          r_state  <= (w_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: if (mem_ready) begin r_mdr <= mem_rdata; r_state <= S_MEMWB; end
        S_MEMWR: if (mem_ready) begin r_instret <= r_instret + 32'd1; r_state <= S_FETCH; end
        S_EXECR, S_EXECI: begin r_aluout <= w_alu_y; r_state <= S_ALUWB; end
        S_MEMWB, S_ALUWB: begin r_instret <= r_instret + 32'd1; r_state <= S_FETCH; end
        S_BRANCH: begin
          if (w_br_taken) r_pc <= r_aluout;
          r_instret <= r_instret + 32'd1;
          r_state   <= S_FETCH;
        end
        S_JAL: begin r_pc <= r_aluout; r_aluout <= w_alu_y; r_state <= S_ALUWB; end
`ifdef RISC_V_MC_ILLEGAL_TRAP_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Register file: single write port, used only in the write-back states; x0 never written
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if ((r_state == S_MEMWB || r_state == S_ALUWB) && w_rd != 5'd0) begin
      r_rf[w_rd] <= (r_state == S_MEMWB) ? r_mdr : r_aluout;
    end
  end

`ifdef RISC_V_MC_ILLEGAL_TRAP_EN
  logic r_illegal;
  // Sticky trap flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !(w_is_mem || w_is_r || w_is_i || w_is_br || w_is_jal))
      r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign w_word_addr = (r_state == S_FETCH) ? r_pc[ADDR_WIDTH-1:2] : r_aluout[ADDR_WIDTH-1:2];
  assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign mem_we    = (r_state == S_MEMWR);
  assign mem_addr  = {w_word_addr, 2'b00};
  assign mem_wdata = (r_state == S_MEMWR) ? r_b : '0;
  assign a0        = r_rf[10];
  assign instret   = r_instret;
endmodule

// File: tb/tb_risc_v_multicycle.sv
// Directed bench for risc_v_multicycle: table of short programs plus hand-written
// stall, loop, reset-during-store and illegal-instruction sequences.
module tb_risc_v_multicycle;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mem_req, mem_we, mem_ready, illegal;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, a0, instret;

  logic [31:0] mem [0:63];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;
  int          st_cnt = 0;
  logic [15:0] st_addr = '0;
  logic [31:0] st_data = '0;

  int n_total = 0;
  int n_bad = 0;

  risc_v_multicycle dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .a0(a0), .instret(instret), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr[7:2]];

  // memory model: bench load port, otherwise completed stores
  always @(posedge CLK) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      st_cnt  <= st_cnt + 1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end
  end

  typedef struct {
    logic [31:0] w0, w1, w2;
    int          cycles;
    logic [31:0] a0, instret, addr;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = idx[5:0]; ld_data = d;
    tick(1);
    ld_en = 1'b0;
  endtask

  // holds reset while loading the program, then releases it in FETCH at address 0
  task automatic reset_load(input logic [31:0] w0, w1, w2, w3);
    RST = 1'b1; mem_ready = 1'b1;
    load(0, w0); load(1, w1); load(2, w2); load(3, w3); load(32, 32'h0);
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    mem_ready = 1'b1;
    vecs[0]  = '{32'h00500513, 32'h0, 32'h0, 4, 32'h5, 1, 32'd4};
    vecs[1]  = '{32'h04000093, 32'h08102023, 32'h08002503, 13, 32'h40, 3, 32'd12};
    vecs[2]  = '{32'hFFF00513, 32'h0, 32'h0, 4, 32'hFFFFFFFF, 1, 32'd4};
    vecs[3]  = '{32'h00700093, 32'hFFD00113, 32'h40208533, 12, 32'd10, 3, 32'd12};
    vecs[4]  = '{32'h00700093, 32'hFFD00113, 32'h00112533, 12, 32'd1, 3, 32'd12};
    vecs[5]  = '{32'h00700093, 32'hFFD00113, 32'h0020F533, 12, 32'd5, 3, 32'd12};
    vecs[6]  = '{32'h00700093, 32'hFFD00113, 32'h0020E533, 12, 32'hFFFFFFFF, 3, 32'd12};
    vecs[7]  = '{32'h00700093, 32'hFFD00113, 32'h00208533, 12, 32'd4, 3, 32'd12};
    vecs[8]  = '{32'h00F00093, 32'h00A0F513, 32'h0, 8, 32'h0A, 2, 32'd8};
    vecs[9]  = '{32'h00F00093, 32'h0300E513, 32'h0, 8, 32'h3F, 2, 32'd8};
    vecs[10] = '{32'hFFB00093, 32'hFFC0A513, 32'h0, 8, 32'd1, 2, 32'd8};
    vecs[11] = '{32'h00500013, 32'h00000533, 32'h0, 8, 32'd0, 2, 32'd8};
    vecs[12] = '{32'h0080056F, 32'h0, 32'h0, 4, 32'd4, 1, 32'd8};
    vecs[13] = '{32'h00000663, 32'h0, 32'h0, 3, 32'd0, 1, 32'd12};
    vecs[14] = '{32'h00001663, 32'h0, 32'h0, 3, 32'd0, 1, 32'd4};
    vecs[15] = '{32'h00700093, 32'h00008663, 32'h0, 7, 32'd0, 2, 32'd8};
    vecs[16] = '{32'h00700093, 32'h00009663, 32'h0, 7, 32'd0, 2, 32'd16};
    vecs[17] = '{32'h00700093, 32'hFFD00113, 32'h0020A533, 12, 32'd0, 3, 32'd12};

    // reset state
    reset_load(32'h00500513, 32'h0, 32'h0, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'd1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_a0", a0, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // table of short programs, ready tied high
    for (int i = 0; i < 18; i++) begin
      reset_load(vecs[i].w0, vecs[i].w1, vecs[i].w2, 32'h0);
      tick(vecs[i].cycles);
      chk($sformatf("v%0d_a0", i), a0, vecs[i].a0);
      chk($sformatf("v%0d_instret", i), instret, vecs[i].instret);
      chk($sformatf("v%0d_addr", i), {16'd0, mem_addr}, vecs[i].addr);
    end

    // lw with ready low for 3 cycles in MEMRD; data kept at 0x80, away from the program words
    reset_load(32'h04000093, 32'h08102023, 32'h08002503, 32'h0);
    s0 = st_cnt;
    tick(8);
    chk("sw_count", st_cnt - s0, 32'd1);
    chk("sw_addr", {16'd0, st_addr}, 32'h80);
    chk("sw_data", st_data, 32'h40);
    tick(3);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_req", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("stall%0d_addr", k), {16'd0, mem_addr}, 32'h80);
      chk($sformatf("stall%0d_we", k), {31'd0, mem_we}, 32'd0);
      chk($sformatf("stall%0d_a0", k), a0, 32'd0);
      if (k < 3) tick(1);
    end
    mem_ready = 1'b1;
    tick(1);
    chk("stall_memwb_a0", a0, 32'd0);
    tick(1);
    chk("stall_done_a0", a0, 32'h40);
    chk("stall_done_instret", instret, 32'd3);
    chk("stall_done_addr", {16'd0, mem_addr}, 32'd12);

    // bne countdown loop then jal x0,0
    reset_load(32'h00300513, 32'hFFF50513, 32'hFE051EE3, 32'h0000006F);
    tick(4);
    chk("loop_init_a0", a0, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick(4);
      chk($sformatf("loop%0d_a0", k), a0, 32'(2 - k));
      tick(3);
      chk($sformatf("loop%0d_pc", k), {16'd0, mem_addr}, (k < 2) ? 32'd4 : 32'd12);
    end
    chk("loop_instret", instret, 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick(4);
      chk($sformatf("jal%0d_pc", k), {16'd0, mem_addr}, 32'd12);
    end
    chk("jal_instret", instret, 32'd10);

    // reset while a store waits for ready
    reset_load(32'h00500513, 32'h08A02023, 32'h0, 32'h0);
    s0 = st_cnt;
    tick(4);
    chk("rw_a0", a0, 32'd5);
    tick(3);
    mem_ready = 1'b0;
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    chk("rw_addr", {16'd0, mem_addr}, 32'h80);
    chk("rw_wdata", mem_wdata, 32'd5);
    tick(1);
    chk("rw_hold_we", {31'd0, mem_we}, 32'd1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    mem_ready = 1'b1;
    chk("rw_rst_req", {31'd0, mem_req}, 32'd1);
    chk("rw_rst_we", {31'd0, mem_we}, 32'd0);
    chk("rw_rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rw_rst_a0", a0, 32'd0);
    chk("rw_rst_instret", instret, 32'd0);
    chk("rw_no_store", st_cnt - s0, 32'd0);

    // opcode 0x7F
    reset_load(32'h0000007F, 32'h00500513, 32'h0, 32'h0);
`ifdef RISC_V_MC_ILLEGAL_TRAP_EN
    tick(2);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_req", {31'd0, mem_req}, 32'd0);
    tick(10);
    chk("ill_req_later", {31'd0, mem_req}, 32'd0);
    chk("ill_instret", instret, 32'd0);
    chk("ill_a0", a0, 32'd0);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("ill_rst_flag", {31'd0, illegal}, 32'd0);
    chk("ill_rst_req", {31'd0, mem_req}, 32'd1);
`else
    tick(2);
    chk("nop_addr", {16'd0, mem_addr}, 32'd4);
    chk("nop_instret", instret, 32'd1);
    chk("nop_illegal", {31'd0, illegal}, 32'd0);
    chk("nop_req", {31'd0, mem_req}, 32'd1);
    tick(4);
    chk("nop_next_a0", a0, 32'd5);
    chk("nop_next_instret", instret, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
